// File: rtl/parking_pkg.sv
// Shared definitions for the parking gate actuator: state encoding and default travel/timer constants.
package parking_pkg;

    typedef enum logic [2:0] {
        GATE_CLOSED,
        GATE_OPENING,
        GATE_OPEN,
        GATE_CLOSING,
        GATE_FAULT
    } gate_state_t;

    localparam int TRAVEL_TICKS_DEF = 100;
    localparam int HOLD_CYCLES_DEF  = 5000;
    localparam int STALL_CYCLES_DEF = 200;

    // A timer loaded with N-1 reaches zero after exactly N counting cycles.
    function automatic int timer_load(input int cycles);
        return (cycles > 0) ? cycles - 1 : 0;
    endfunction

endpackage

// File: rtl/parking_gate_drive_if.sv
// Command/status bundle between the parking controller (master) and the gate drive stage (slave).
interface parking_gate_drive_if
    import parking_pkg::*;
#(
    parameter int POS_W = 8
) ();

    // Commands are levels except posTick (one-cycle encoder tick) and faultClr (pulse);
    // every status output is registered in the drive and changes one cycle after its cause.
    logic             doorOpen;
    logic             doorClose;
    logic             posTick;
    logic             obstacle;
    logic             faultClr;
    logic             motorUp;
    logic             motorDown;
    logic             doorMaxOpen;
    logic             doorMaxClose;
    logic [POS_W-1:0] gatePos;
    logic             fault;
    gate_state_t      state;

    modport master (
        output doorOpen, doorClose, posTick, obstacle, faultClr,
        input  motorUp, motorDown, doorMaxOpen, doorMaxClose, gatePos, fault, state
    );

    modport slave (
        input  doorOpen, doorClose, posTick, obstacle, faultClr,
        output motorUp, motorDown, doorMaxOpen, doorMaxClose, gatePos, fault, state
    );

endinterface

// File: rtl/gate_timer.sv
// Loadable down-counter; expired is high while the count sits at zero.
module gate_timer #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    output logic         expired
);

    logic [W-1:0] count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (en && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign expired = (count == '0);

endmodule

// File: rtl/parking_gate_drive.sv
// Gate actuator: motor drive FSM, encoder position tracking, limit pulses, obstacle reversal,
// auto-close hold timer and stall fault.
module parking_gate_drive
    import parking_pkg::*;
#(
    parameter int TRAVEL_TICKS = TRAVEL_TICKS_DEF,
    parameter int POS_W        = 8,
    parameter int HOLD_CYCLES  = HOLD_CYCLES_DEF,
    parameter int STALL_CYCLES = STALL_CYCLES_DEF,
    parameter int TMR_W        = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    parking_gate_drive_if.slave  gate
);

    localparam logic [POS_W-1:0] TOP        = POS_W'(TRAVEL_TICKS);
    localparam logic [TMR_W-1:0] HOLD_LOAD  = TMR_W'(timer_load(HOLD_CYCLES));
    localparam logic [TMR_W-1:0] STALL_LOAD = TMR_W'(timer_load(STALL_CYCLES));
    localparam bit               HOLD_ON    = (HOLD_CYCLES > 0);

    gate_state_t      state, next_state;
    logic [POS_W-1:0] pos, pos_next;
    logic             motor_up, motor_down, max_open, max_close, fault_q;
    logic             hold_load, hold_en, hold_exp;
    logic             stall_load, stall_en, stall_exp, stalled;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= GATE_CLOSED;
        end else begin
            state <= next_state;
        end
    end

    // Position saturates at both ends; ticks only count while the motor is commanded.
    always_comb begin
        pos_next = pos;
        if (gate.posTick) begin
            if ((state == GATE_OPENING) && (pos < TOP)) begin
                pos_next = pos + 1'b1;
            end else if ((state == GATE_CLOSING) && (pos != '0)) begin
                pos_next = pos - 1'b1;
            end
        end
    end

    assign stalled = stall_exp && !gate.posTick;

    always_comb begin
        next_state = state;
        unique case (state)
            GATE_CLOSED: begin
                if (gate.doorOpen) next_state = GATE_OPENING;
            end
            GATE_OPENING: begin
                if (stalled)               next_state = GATE_FAULT;
                else if (pos_next == TOP)  next_state = GATE_OPEN;
            end
            GATE_OPEN: begin
                if (!gate.doorOpen && !gate.obstacle && (gate.doorClose || (HOLD_ON && hold_exp)))
                    next_state = GATE_CLOSING;
            end
            GATE_CLOSING: begin
                if (stalled)                              next_state = GATE_FAULT;
                else if (gate.obstacle || gate.doorOpen)  next_state = GATE_OPENING;
                else if (pos_next == '0)                  next_state = GATE_CLOSED;
            end
            GATE_FAULT: begin
                if (gate.faultClr) next_state = GATE_OPENING;
            end
            default: next_state = GATE_CLOSED;
        endcase
    end

    assign stall_load = gate.posTick || (next_state != state);
    assign stall_en   = (state == GATE_OPENING) || (state == GATE_CLOSING);
    assign hold_load  = ((next_state == GATE_OPEN) && (state != GATE_OPEN)) ||
                        ((state == GATE_OPEN) && gate.doorOpen);
    assign hold_en    = (state == GATE_OPEN);

    gate_timer #(.W(TMR_W)) u_hold (
        .clk      (clk),
        .rst      (rst),
        .load     (hold_load),
        .load_val (HOLD_LOAD),
        .en       (hold_en),
        .expired  (hold_exp)
    );

    gate_timer #(.W(TMR_W)) u_stall (
        .clk      (clk),
        .rst      (rst),
        .load     (stall_load),
        .load_val (STALL_LOAD),
        .en       (stall_en),
        .expired  (stall_exp)
    );

    // A reversal out of CLOSING holds motorUp low for its first OPENING cycle (dead time).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pos        <= '0;
            motor_up   <= 1'b0;
            motor_down <= 1'b0;
            max_open   <= 1'b0;
            max_close  <= 1'b0;
            fault_q    <= 1'b0;
        end else begin
            pos        <= pos_next;
            motor_up   <= (next_state == GATE_OPENING) && (state != GATE_CLOSING);
            motor_down <= (next_state == GATE_CLOSING);
            max_open   <= (state == GATE_OPENING) && (next_state == GATE_OPEN);
            max_close  <= (state == GATE_CLOSING) && (next_state == GATE_CLOSED);
            fault_q    <= (next_state == GATE_FAULT);
        end
    end

    assign gate.motorUp      = motor_up;
    assign gate.motorDown    = motor_down;
    assign gate.doorMaxOpen  = max_open;
    assign gate.doorMaxClose = max_close;
    assign gate.gatePos      = pos;
    assign gate.fault        = fault_q;
    assign gate.state        = state;

endmodule

// File: tb/tb_parking_gate_drive.sv
// Self-checking bench for parking_gate_drive with TRAVEL_TICKS=4, HOLD_CYCLES=20, STALL_CYCLES=8.
module tb_parking_gate_drive;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    // Inputs packed {doorOpen, doorClose, posTick, obstacle, faultClr};
    // expected packed {motorUp, motorDown, doorMaxOpen, doorMaxClose, fault, gatePos[7:0]}.
    typedef struct {
        logic [4:0]  in;
        logic [12:0] exp;
    } vec_t;

    vec_t        vecs[$];
    logic [12:0] exp_q[$];

    parking_gate_drive_if #(.POS_W(8)) bus ();

    parking_gate_drive #(
        .TRAVEL_TICKS (4),
        .POS_W        (8),
        .HOLD_CYCLES  (20),
        .STALL_CYCLES (8),
        .TMR_W        (16)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .gate (bus)
    );

    always #5 clk = ~clk;

    task automatic compare(input string name);
        logic [12:0] got, exp;
        got = {bus.motorUp, bus.motorDown, bus.doorMaxOpen, bus.doorMaxClose, bus.fault, bus.gatePos};
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL %s: scoreboard empty, got %h", name, got);
        end else begin
            exp = exp_q.pop_front();
            if (got !== exp) begin
                errors++;
                $display("FAIL %s: got %b_%0d required %b_%0d", name, got[12:8], got[7:0], exp[12:8], exp[7:0]);
            end
        end
    endtask

    task automatic step(input logic [4:0] in, input logic [12:0] exp, input string name);
        {bus.doorOpen, bus.doorClose, bus.posTick, bus.obstacle, bus.faultClr} = in;
        exp_q.push_back(exp);
        @(posedge clk);
        #1;
        compare(name);
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            checks++;
            if (bus.motorUp && bus.motorDown) begin
                errors++;
                $display("FAIL motor_exclusive: got up=1 down=1 required not both");
            end
        end
    end

    initial begin
        {bus.doorOpen, bus.doorClose, bus.posTick, bus.obstacle, bus.faultClr} = 5'b00000;

        // Open, close, ignored ticks, open-wins, obstacle reversal, doorOpen reversal.
        vecs.push_back('{5'b10000, {5'b10000, 8'd0}});
        vecs.push_back('{5'b10100, {5'b10000, 8'd1}});
        vecs.push_back('{5'b00100, {5'b10000, 8'd2}});
        vecs.push_back('{5'b00100, {5'b10000, 8'd3}});
        vecs.push_back('{5'b00000, {5'b10000, 8'd3}});
        vecs.push_back('{5'b00100, {5'b00100, 8'd4}});
        vecs.push_back('{5'b00000, {5'b00000, 8'd4}});
        vecs.push_back('{5'b00100, {5'b00000, 8'd4}});
        vecs.push_back('{5'b01000, {5'b01000, 8'd4}});
        vecs.push_back('{5'b00100, {5'b01000, 8'd3}});
        vecs.push_back('{5'b00100, {5'b01000, 8'd2}});
        vecs.push_back('{5'b00100, {5'b01000, 8'd1}});
        vecs.push_back('{5'b00100, {5'b00010, 8'd0}});
        vecs.push_back('{5'b00000, {5'b00000, 8'd0}});
        vecs.push_back('{5'b00100, {5'b00000, 8'd0}});
        vecs.push_back('{5'b01000, {5'b00000, 8'd0}});
        vecs.push_back('{5'b11000, {5'b10000, 8'd0}});
        vecs.push_back('{5'b00100, {5'b10000, 8'd1}});
        vecs.push_back('{5'b00100, {5'b10000, 8'd2}});
        vecs.push_back('{5'b00100, {5'b10000, 8'd3}});
        vecs.push_back('{5'b00100, {5'b00100, 8'd4}});
        vecs.push_back('{5'b01000, {5'b01000, 8'd4}});
        vecs.push_back('{5'b00100, {5'b01000, 8'd3}});
        vecs.push_back('{5'b00100, {5'b01000, 8'd2}});
        vecs.push_back('{5'b00010, {5'b00000, 8'd2}});
        vecs.push_back('{5'b00010, {5'b10000, 8'd2}});
        vecs.push_back('{5'b00100, {5'b10000, 8'd3}});
        vecs.push_back('{5'b00100, {5'b00100, 8'd4}});
        vecs.push_back('{5'b00000, {5'b00000, 8'd4}});
        vecs.push_back('{5'b01000, {5'b01000, 8'd4}});
        vecs.push_back('{5'b00100, {5'b01000, 8'd3}});
        vecs.push_back('{5'b11000, {5'b00000, 8'd3}});
        vecs.push_back('{5'b00000, {5'b10000, 8'd3}});
        vecs.push_back('{5'b00100, {5'b00100, 8'd4}});
        vecs.push_back('{5'b00000, {5'b00000, 8'd4}});

        repeat (2) @(posedge clk);
        #1;
        exp_q.push_back({5'b00000, 8'd0});
        compare("reset_state");
        rst = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].in, vecs[i].exp, $sformatf("vec%0d", i));
        end

        // Auto-close: OPEN entered one edge before the last table row; closes on the 20th edge.
        for (int k = 2; k <= 19; k++) begin
            step(5'b00000, {5'b00000, 8'd4}, $sformatf("hold_wait%0d", k));
        end
        step(5'b00000, {5'b01000, 8'd4}, "auto_close");

        // Back to OPEN via an obstacle reversal, then hold open under a blocked beam.
        step(5'b00100, {5'b01000, 8'd3}, "ac_tick");
        step(5'b00010, {5'b00000, 8'd3}, "ac_rev_dead");
        step(5'b00010, {5'b10000, 8'd3}, "ac_rev_up");
        step(5'b00110, {5'b00100, 8'd4}, "ac_reopen");
        for (int k = 0; k < 25; k++) begin
            step(5'b00010, {5'b00000, 8'd4}, $sformatf("obst_hold%0d", k));
        end
        step(5'b01010, {5'b00000, 8'd4}, "close_blocked");
        step(5'b01000, {5'b01000, 8'd4}, "close_clear");
        step(5'b00100, {5'b01000, 8'd3}, "pre_reset_pos3");

        // Asynchronous reset mid-cycle, checked before any further clock edge.
        bus.posTick = 1'b0;
        bus.doorClose = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        exp_q.push_back({5'b00000, 8'd0});
        compare("async_reset");
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Stall: eight OPENING cycles without a tick latch the fault.
        step(5'b10000, {5'b10000, 8'd0}, "stall_enter");
        for (int k = 1; k <= 7; k++) begin
            step(5'b00000, {5'b10000, 8'd0}, $sformatf("stall_wait%0d", k));
        end
        step(5'b00000, {5'b00001, 8'd0}, "stall_fault");
        step(5'b10000, {5'b00001, 8'd0}, "fault_holds");
        step(5'b00001, {5'b10000, 8'd0}, "fault_clear");
        step(5'b00100, {5'b10000, 8'd1}, "after_clear_tick");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
